// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state machine, sample points.
// Sample-point helpers take OVS so that the receiver and the future transmitter derive them identically.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  // Three samples straddle the bit centre; the middle one sits at OVS/2.
  function automatic int samp_first(input int ovs);
    return ovs / 2 - 1;
  endfunction

  function automatic int samp_mid(input int ovs);
    return ovs / 2;
  endfunction

  function automatic int samp_last(input int ovs);
    return ovs / 2 + 1;
  endfunction

  // Encoding 2'b11 is treated as no parity.
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div and pulses tick on the terminal count; latency one div+1 cycle period.
// No backpressure; counter is held at zero whenever en is low or clr is high.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = en && !clr && (cnt == div);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote sampling, parity/framing checks; result registered one clk after the last stop sample.
// No backpressure: data_valid is a single-cycle pulse. UART_RX_BREAK_DET_EN adds break_det and a post-break idle wait.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam int OW  = $clog2(OVS);
  localparam int BCW = $clog2(DATA_BITS + 5);

  localparam logic [OW-1:0]  SP0      = OW'(samp_first(OVS));
  localparam logic [OW-1:0]  SP1      = OW'(samp_mid(OVS));
  localparam logic [OW-1:0]  SP2      = OW'(samp_last(OVS));
  localparam logic [OW-1:0]  OVS_MAX  = OW'(OVS - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  rx_state_e            state;
  logic                 rx_m, rx_s, rx_d;
  logic [DIV_W-1:0]     div_l;
  logic [1:0]           par_l;
  logic                 stop2_l;
  logic [OW-1:0]        ovs_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0, s1;
  logic                 perr_l;
  logic                 ferr_acc;

  logic tick, fall, samp0, samp1, samp2, bit_end, maj;
  logic par_calc, perr_now, last_data, last_stop;

  // Falling edge seen by the delay flop is the only way out of IDLE.
  assign fall      = rx_d & ~rx_s;
  assign samp0     = tick && (ovs_cnt == SP0);
  assign samp1     = tick && (ovs_cnt == SP1);
  assign samp2     = tick && (ovs_cnt == SP2);
  assign bit_end   = tick && (ovs_cnt == OVS_MAX);
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign par_calc  = (^shreg) ^ maj;
  assign perr_now  = (par_l == PAR_ODD) ? ~par_calc : par_calc;
  assign last_data = (bit_cnt == LAST_BIT);
  assign last_stop = (bit_cnt == {{(BCW-1){1'b0}}, stop2_l});

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit;
  logic zero_frame;
  assign zero_frame = (shreg == '0) && (!parity_en(par_l) || !par_bit) && !maj
                      && (bit_cnt == '0);
`endif

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .clr   ((state == IDLE) && fall),
    .div   (div_l),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      div_l      <= '0;
      par_l      <= PAR_NONE;
      stop2_l    <= 1'b0;
      ovs_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      perr_l     <= 1'b0;
      ferr_acc   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit    <= 1'b0;
      break_det  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
`endif
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;

      if (samp0) s0 <= rx_s;
      if (samp1) s1 <= rx_s;
      if (tick && (state != IDLE)) begin
        ovs_cnt <= (ovs_cnt == OVS_MAX) ? '0 : ovs_cnt + OW'(1);
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            busy     <= 1'b1;
            div_l    <= cfg_div;
            par_l    <= cfg_parity;
            stop2_l  <= cfg_stop2;
            ovs_cnt  <= '0;
            bit_cnt  <= '0;
            perr_l   <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end

        START: begin
          if (samp2 && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (samp2) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (last_data) begin
              bit_cnt <= '0;
              state   <= parity_en(par_l) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end

        PARITY: begin
          if (samp2) begin
            perr_l <= perr_now;
`ifdef UART_RX_BREAK_DET_EN
            par_bit <= maj;
`endif
          end else if (bit_end) begin
            state <= STOP;
          end
        end

        // IDLE is re-entered at the last stop sample so a start edge in the
        // back half of the stop bit is still caught.
        STOP: begin
          if (samp2) begin
`ifdef UART_RX_BREAK_DET_EN
            if (zero_frame) begin
              break_det <= 1'b1;
              state     <= BRK_WAIT;
              ovs_cnt   <= '0;
            end else
`endif
            if (last_stop) begin
              state      <= IDLE;
              busy       <= 1'b0;
              data_valid <= 1'b1;
              data_out   <= shreg;
              parity_err <= perr_l;
              frame_err  <= ferr_acc | ~maj;
            end else begin
              ferr_acc <= ferr_acc | ~maj;
            end
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end

        // Line must stay high for one whole bit before the receiver re-arms.
        BRK_WAIT: begin
          if (!rx_s) begin
            ovs_cnt <= '0;
          end else if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
